// File: rtl/shift_reg_ctrl.sv
// Job sequencer for a WIDTH-bit load/shift register: tx (parallel-to-serial) or rx (serial-to-parallel).
// Optional parity phase after shifting is enabled by defining SHIFT_REG_CTRL_PARITY_EN.
`timescale 1ns/1ps

module shift_reg_ctrl #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [WIDTH-1:0] req_data,
  output logic             sr_load,
  output logic             sr_shift,
  output logic [WIDTH-1:0] sr_d,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
`ifdef SHIFT_REG_CTRL_PARITY_EN
  ,
  output logic             par_bit,
  output logic             par_valid
`endif
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
`ifdef SHIFT_REG_CTRL_PARITY_EN
    S_PARITY,
`endif
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q;
  logic             mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             accept;
  logic             bit_tick;
`ifdef SHIFT_REG_CTRL_PARITY_EN
  logic             par_valid_c;
`endif

  assign accept   = (state_q == S_IDLE) && req_valid && ready_q;
  assign bit_tick = (div_q == DIV_LAST);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    done     = 1'b0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
    par_valid_c = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: begin
        sr_load = 1'b1;
        div_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        div_d = bit_tick ? '0 : div_q + 1'b1;
        if (bit_tick) begin
          sr_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
`ifdef SHIFT_REG_CTRL_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef SHIFT_REG_CTRL_PARITY_EN
      // Parity phase reuses the bit-period divider so it lasts one bit time.
      S_PARITY: begin
        par_valid_c = 1'b1;
        div_d       = bit_tick ? '0 : div_q + 1'b1;
        if (bit_tick) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every register here is a flop, so all are reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      mode_q     <= 1'b0;
      data_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      ready_q    <= (state_d == S_IDLE);
      rx_valid_q <= (state_q == S_DONE) && mode_q;
      if (accept) begin
        mode_q <= req_mode;
        data_q <= req_data;
      end
      if ((state_q == S_DONE) && mode_q) rx_data_q <= sr_q;
    end
  end

  // rx jobs load zeros so the received word is built only from shifted-in bits.
  assign sr_d      = ((state_q == S_LOAD) && !mode_q) ? data_q : '0;
  assign req_ready = ready_q;
  assign busy      = (state_q != S_IDLE);
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;

`ifdef SHIFT_REG_CTRL_PARITY_EN
  assign par_valid = par_valid_c;
  assign par_bit   = par_valid_c ? (mode_q ? ^sr_q : ^data_q) : 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Scoreboard bench for shift_reg_ctrl: two instances (CLKS_PER_BIT 1 and 3), each driving a
// behavioural shift register; parity checks compile in when SHIFT_REG_CTRL_PARITY_EN is defined.
`timescale 1ns/1ps

module tb_shift_reg_ctrl;
  localparam int W = 4;

  typedef struct packed {
    logic         mode;
    logic [W-1:0] data;
    logic [W-1:0] rxw;
    logic         b2b;
    logic         abort;
  } job_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int C = (g == 0) ? 1 : 3;
`ifdef SHIFT_REG_CTRL_PARITY_EN
    localparam int PAR = C;
`else
    localparam int PAR = 0;
`endif
    localparam int LIMIT = W * C + 1 + PAR;

    logic         rst_n, req_valid, req_ready, req_mode, sr_load, sr_shift, busy, done, rx_valid;
    logic [W-1:0] req_data, sr_d, sr_q, rx_data;
`ifdef SHIFT_REG_CTRL_PARITY_EN
    logic         par_bit, par_valid;
`endif
    logic [W-1:0] env_sr, env_sin, rx_word_cur;
    logic         fin;
    job_t         exp_q[$];

    shift_reg_ctrl #(.WIDTH(W), .CLKS_PER_BIT(C)) u_dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_data(req_data),
      .sr_load(sr_load), .sr_shift(sr_shift), .sr_d(sr_d), .sr_q(sr_q),
      .busy(busy), .done(done), .rx_data(rx_data), .rx_valid(rx_valid)
`ifdef SHIFT_REG_CTRL_PARITY_EN
      , .par_bit(par_bit), .par_valid(par_valid)
`endif
    );

    // Shift register under control: shifts left, serial input into the LSB, serial output from the MSB.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        env_sr  <= '0;
        env_sin <= '0;
      end else if (sr_load) begin
        env_sr  <= sr_d;
        env_sin <= rx_word_cur;
      end else if (sr_shift) begin
        env_sr  <= {env_sr[W-2:0], env_sin[W-1]};
        env_sin <= env_sin << 1;
      end
    end
    assign sr_q = env_sr;

    // Monitor: pops the expected job when done appears and compares everything observed for it.
    initial begin
      job_t         cur;
      bit           active, pend, pend_mode;
      int           t, nsh, npar;
      logic [W-1:0] txbits, last_rx, pend_rxw;
      active = 0; pend = 0; pend_mode = 0; t = 0; nsh = 0; npar = 0;
      txbits = '0; last_rx = '0; pend_rxw = '0; cur = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          active = 0; pend = 0; last_rx = '0;
          continue;
        end
        check("load_shift_exclusive", 32'(sr_load & sr_shift), 0);
        check("busy_vs_ready", 32'(busy), 32'(!req_ready));
        if (pend) begin
          pend = 0;
          check("ready_after_done", 32'(req_ready), 1);
          if (pend_mode) begin
            check("rx_valid_pulse", 32'(rx_valid), 1);
            check("rx_data", 32'(rx_data), 32'(pend_rxw));
            last_rx = pend_rxw;
          end else begin
            check("tx_no_rx_valid", 32'(rx_valid), 0);
            check("rx_data_held", 32'(rx_data), 32'(last_rx));
          end
        end else begin
          check("rx_valid_quiet", 32'(rx_valid), 0);
        end
        if (!active) begin
          if (sr_load) begin
            check("load_has_job", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) cur = exp_q[0];
            check("sr_d", 32'(sr_d), 32'(cur.mode ? '0 : cur.data));
            active = 1; t = 0; nsh = 0; npar = 0; txbits = '0;
          end else begin
            check("idle_strobes", 32'({sr_shift, done}), 0);
          end
        end else begin
          t++;
          check("no_reload", 32'(sr_load), 0);
          if (sr_shift) begin
            check("shift_time", t, C * (nsh + 1));
            txbits = {txbits[W-2:0], env_sr[W-1]};
            nsh++;
          end
`ifdef SHIFT_REG_CTRL_PARITY_EN
          if (par_valid) begin
            check("par_window", 32'(t > W * C && t <= W * C + C), 1);
            check("par_bit", 32'(par_bit), 32'(cur.mode ? ^cur.rxw : ^cur.data));
            npar++;
          end
`endif
          if (done) begin
            check("done_time", t, LIMIT);
            check("shift_count", nsh, W);
            check("par_cycles", npar, PAR);
            if (!cur.mode) check("tx_serial", 32'(txbits), 32'(cur.data));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            pend = 1; pend_mode = cur.mode; pend_rxw = cur.rxw;
            active = 0;
          end else if (t > LIMIT) begin
            check("job_overrun", t, LIMIT);
            active = 0;
          end
        end
      end
    end

    // Stimulus: directed jobs from the test plan, then random ones; garbage requests while busy.
    initial begin
      job_t jobs[$];
      job_t j;
      int   n, nsh;
      fin = 0; rst_n = 0; req_valid = 0; req_mode = 0; req_data = '0; rx_word_cur = '0;
      #10;
      check("reset_outputs", 32'({req_ready, sr_load, sr_shift, busy, done, rx_valid, sr_d, rx_data}), 0);
      #3 rst_n = 1;
      @(posedge clk); #1;
      check("ready_after_release", 32'(req_ready), 1);
      check("busy_after_release", 32'(busy), 0);
      @(negedge clk);

      jobs.push_back('{mode: 1'b0, data: 4'b1010, rxw: 4'b0000, b2b: 1'b0, abort: 1'b0});
      jobs.push_back('{mode: 1'b1, data: 4'b1111, rxw: 4'b1001, b2b: 1'b0, abort: 1'b0});
      jobs.push_back('{mode: 1'b0, data: 4'b0110, rxw: 4'b0011, b2b: 1'b0, abort: 1'b0});
      jobs.push_back('{mode: 1'b1, data: 4'b0101, rxw: 4'b0110, b2b: 1'b0, abort: 1'b1});
      jobs.push_back('{mode: 1'b0, data: 4'b1011, rxw: 4'b0000, b2b: 1'b1, abort: 1'b0});
      jobs.push_back('{mode: 1'b1, data: 4'b0000, rxw: 4'b1110, b2b: 1'b0, abort: 1'b0});
      for (int k = 0; k < 24; k++) begin
        j.mode  = 1'($urandom);
        j.data  = W'($urandom);
        j.rxw   = W'($urandom);
        j.b2b   = 1'($urandom);
        j.abort = ($urandom_range(0, 9) == 0);
        jobs.push_back(j);
      end

      for (int k = 0; k < jobs.size(); k++) begin
        j = jobs[k];
        req_valid = 1; req_mode = j.mode; req_data = j.data;
        n = 0;
        while (!req_ready && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("accept_ready", 32'(req_ready), 1);
        if (!req_ready) break;
        rx_word_cur = j.rxw;
        exp_q.push_back(j);
        n = 0; nsh = 0;
        forever begin
          @(negedge clk);
          n++;
          if (n == 1) check("load_after_accept", 32'(sr_load), 1);
          if (done) break;
          if (sr_shift) nsh++;
          if (j.abort && nsh == 2) break;
          if (n > 200) break;
          req_valid = 1'($urandom); req_mode = 1'($urandom); req_data = W'($urandom);
        end
        if (j.abort) begin
          #2 rst_n = 0;
          exp_q.delete();
          #1;
          check("abort_quiet", 32'({sr_load, sr_shift, done, busy, req_ready, rx_valid, rx_data}), 0);
          req_valid = 0;
          @(negedge clk);
          @(negedge clk);
          #3 rst_n = 1;
          @(negedge clk);
        end else begin
          check("job_completed", 32'(done), 1);
          if (!j.b2b) begin
            req_valid = 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
          end
        end
      end
      req_valid = 0;
      repeat (6) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      fin = 1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(g_inst[0].fin && g_inst[1].fin) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("all_jobs_finished", 32'(g_inst[0].fin && g_inst[1].fin), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
